// File: rtl/fifo_umbral_pkg.sv
// Shared definitions for the switch-datapath FIFOs: default geometry, depth
// derivation and the slot each FIFO instance occupies in the status buses.
package fifo_umbral_pkg;

    localparam int DATA_W_DEFAULT = 6;
    localparam int ADDR_W_DEFAULT = 2;

    // Depth is always a power of two so pointers wrap naturally.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Bit positions inside the FIFO_errors / FIFO_empties buses.
    typedef enum int {
        FIFO_MF  = 0,
        FIFO_VC0 = 1,
        FIFO_VC1 = 2,
        FIFO_D0  = 3,
        FIFO_D1  = 4
    } fifo_slot_e;

    localparam int FIFO_COUNT = 5;

endpackage

// File: rtl/fifo_umbral_mem.sv
// Storage array for fifo_umbral: one synchronous write port, one
// asynchronous read port. Contents are deliberately left unreset; the
// owner registers the read data so the read latency stays at one cycle.
module fifo_umbral_mem
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port sees pre-edge contents, so a same-edge write is never bypassed.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with run-time almost-full / almost-empty thresholds and
// a sticky overflow/underflow error flag. Pointers, occupancy, flags and the
// error live here; the word storage lives in fifo_umbral_mem.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   af_thr,
    input  logic [ADDR_W:0]   ae_thr,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error
);

    localparam int              DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              valid_out_reg;
    logic              error_reg;

    logic              pop_acc;
    logic              push_acc;
    logic              violation;
    logic [DATA_W-1:0] rd_data;

    // Flags derive from the registered occupancy; thresholds are compared live,
    // so out-of-range thresholds saturate the almost_* flags naturally.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign almost_full  = (count_reg >= af_thr);
    assign almost_empty = (count_reg <= ae_thr);

    assign count      = count_reg;
    assign data_out   = data_out_reg;
    assign valid_out  = valid_out_reg;
    assign fifo_error = error_reg;

    // Accept decisions: a pop frees a slot on a full FIFO, but a push on an
    // empty FIFO cannot feed the same-cycle pop.
    always_comb begin
        pop_acc   = 1'b0;
        push_acc  = 1'b0;
        violation = 1'b0;
        pop_acc   = pop && !empty;
        push_acc  = push && (!full || pop_acc);
        violation = (pop && empty) || (push && full && !pop);
    end

    fifo_umbral_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered read data: capture on an accepted pop, otherwise hold.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= pop_acc;
            if (pop_acc) begin
                data_out_reg <= rd_data;
            end
        end
    end

    // Sticky error: a new violation takes priority over a clear request.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_reg <= 1'b0;
        end else if (violation) begin
            error_reg <= 1'b1;
        end else if (err_clr) begin
            error_reg <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Synchronous single-clock FIFO with run-time almost-full/almost-empty thresholds and an error flag.
- Instantiated once per main, virtual-channel and destination FIFO in the switch datapath.
- Its empty and error outputs are concatenated into the FIFO_empties / FIFO_errors buses consumed by the control FSM.
- Its thresholds come from the same afMF/aeMF/afVC/aeVC/afD/aeD values the FSM latches during INIT.

Parameters:
- DATA_W, 6, payload width in bits.
- ADDR_W, 2, address width; depth = 2**ADDR_W = 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous active-low reset.
- push  in  1  write request.
- data_in  in  DATA_W  write data, sampled with push.
- pop  in  1  read request.
- af_thr  in  ADDR_W+1  almost-full threshold (occupancy).
- ae_thr  in  ADDR_W+1  almost-empty threshold (occupancy).
- err_clr  in  1  synchronous clear of the sticky error.
- data_out  out  DATA_W  registered read data.
- valid_out  out  1  data_out holds a word popped on the previous edge.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= af_thr.
- almost_empty  out  1  count <= ae_thr.
- fifo_error  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous assert, synchronous release effect): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, fifo_error=0.
- Reset values of the combinational flags follow from count=0: empty=1, full=0, almost_empty=1, almost_full=(af_thr==0).
- Storage contents are not reset.
- Write accepted = push && (!full || pop_accepted).
  - Accepted write: mem[wr_ptr]<=data_in, wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Read accepted = pop && !empty. No bypass: a word written this cycle is never readable this cycle.
  - Accepted read: data_out<=mem[rd_ptr] on the same edge, valid_out<=1, rd_ptr increments modulo DEPTH.
  - Read latency = 1 cycle from pop to data_out/valid_out.
  - No accepted read: valid_out<=0 and data_out holds its last value.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. count is never outside 0..DEPTH.
- Full with push && pop: both accepted, count stays DEPTH, no error.
- Empty with push && pop: write accepted; pop is an underflow; count becomes 1; valid_out=0.
- Overflow (push && full && !pop): data dropped, pointers unchanged, fifo_error<=1.
- Underflow (pop && empty): nothing read, fifo_error<=1.
- fifo_error is sticky. It clears only on reset_L low, or on err_clr=1 with no new violation in that cycle; a new violation wins over err_clr.
- Flags empty/full/almost_full/almost_empty are combinational from registered count, so they reflect the state after the last edge.
- Thresholds are compared live; changing them changes the almost_* flags in the same cycle.
- af_thr > DEPTH: almost_full is never asserted.
- ae_thr >= DEPTH: almost_empty is always asserted.
- Reset asserted mid-operation: immediate return to reset values regardless of push/pop. Data in flight is lost.

Decomposition:
- Shared package: DEPTH derivation (2**ADDR_W), default DATA_W/ADDR_W, and the bit positions of each FIFO instance inside the FIFO_errors / FIFO_empties buses (MF=0, VC0=1, VC1=2, D0=3, D1=4).
- Natural sub-module: fifo_mem, a dual-port register array with one write port and one read port, no reset. Pointers, count, flags and error stay in the top.

Test Plan:
- Reset then idle, af_thr=3, ae_thr=1 -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, fifo_error=0, valid_out=0.
- Push 0x11,0x22,0x33,0x04 on consecutive cycles -> count 1,2,3,4; almost_full rises when count=3; full=1 at count=4. Then pop x4 -> data_out 0x11,0x22,0x33,0x04 one cycle after each pop, valid_out=1 each cycle, empty=1 at end.
- Full FIFO, push 0x3F without pop -> fifo_error=1 next edge, count stays 4. Pop x4 returns the original four words (0x3F not stored).
- Empty FIFO, pop -> fifo_error=1, valid_out=0. Then err_clr=1 for one cycle -> fifo_error=0. err_clr and pop-on-empty in the same cycle -> fifo_error stays 1.
- Full FIFO, push 0x2A and pop together -> count stays 4, no error, oldest word on data_out. Continue 6 push+pop cycles -> pointer wrap-around, data order preserved.
- Push 2 words, assert reset_L=0 asynchronously mid-cycle -> outputs go to reset values immediately; after release a pop gives underflow, fifo_error=1.
